icache_axi_bridge: RTL

Memory-side responder for the instruction cache's refill and uncached-fetch ports. Accepts a line-refill request (`rd_req`/`rd_addr`) or an uncached word request (`ucache_ren`/`ucache_addr`), issues the matching AXI4 read burst, assembles the returned beats and answers with a single-cycle `ret_valid` carrying the 256-bit line, or `ucache_rvalid` carrying one word. Sits between the icache and the AXI read interconnect.

---
 rtl/icache_axi_bridge.sv | 120 ++++++++++++
 1 files changed

// File: rtl/icache_axi_bridge.sv
// Memory-side responder for the icache: turns a line-refill or uncached-word request
// into one AXI4 INCR read burst and returns the assembled line or word as a single-cycle pulse.
module icache_axi_bridge #(
  parameter int         LINE_BEATS = 8,
  parameter logic [3:0] AXI_ID     = 4'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic [31:0]                rd_addr,
  output logic                       ret_valid,
  output logic [32*LINE_BEATS-1:0]   ret_data,
  input  logic                       ucache_ren,
  input  logic [31:0]                ucache_addr,
  output logic                       ucache_rvalid,
  output logic [31:0]                ucache_rdata,
  output logic [3:0]                 arid,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [3:0]                 rid,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  // state | meaning
  // IDLE  | waiting for rd_req (priority) or ucache_ren
  // AR    | arvalid high, address held until arready
  // R     | rready high, collecting beats until rlast
  // RET   | one-cycle ret_valid / ucache_rvalid pulse
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] RET  = 2'd3;

  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

  logic [1:0] state;
  logic       kind_line;
  logic [2:0] beat_cnt;

  // ID and response code carry no information this bridge acts on.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rd_addr[4:0], ucache_addr[1:0]};

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      kind_line     <= 1'b0;
      beat_cnt      <= 3'd0;
      araddr        <= 32'd0;
      arlen         <= 8'd0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      ret_valid     <= 1'b0;
      ucache_rvalid <= 1'b0;
      ret_data      <= '0;
      ucache_rdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            araddr    <= {rd_addr[31:5], 5'b0};
            arlen     <= 8'(LINE_BEATS - 1);
            kind_line <= 1'b1;
            arvalid   <= 1'b1;
            state     <= AR;
          end else if (ucache_ren) begin
            araddr    <= {ucache_addr[31:2], 2'b0};
            arlen     <= 8'd0;
            kind_line <= 1'b0;
            arvalid   <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            beat_cnt <= 3'd0;
            // Line is cleared here, not on request, so the previous line stays
            // visible to the icache until the new burst is actually under way.
            if (kind_line) ret_data <= '0;
            state    <= R;
          end
        end
        R: begin
          if (rvalid) begin
            if (kind_line) ret_data[{beat_cnt, 5'b0} +: 32] <= rdata;
            else           ucache_rdata <= rdata;
            if (beat_cnt != LAST_BEAT) beat_cnt <= beat_cnt + 3'd1;
            if (rlast) begin
              rready        <= 1'b0;
              ret_valid     <= kind_line;
              ucache_rvalid <= !kind_line;
              state         <= RET;
            end
          end
        end
        RET: begin
          ret_valid     <= 1'b0;
          ucache_rvalid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
